// File: rtl/reg_writeback_if.sv
// Write-back bus between the execute/memory stages and the register-file
// write front end: load issue, ALU result, load response and the
// registered write port plus scoreboard and queue status.
interface reg_writeback_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LQ_DEPTH = 4
);
  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;
  localparam int NREG  = 1 << ADDR_W;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              alu_stall;
  logic              reg_we;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] rd_data;
  logic [NREG-1:0]   busy;
  logic [CNT_W-1:0]  lq_count;

  // Producer side: decode/execute/memory stages and the register file.
  modport master (
    output issue_valid, issue_rd,
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready, alu_stall,
    input  reg_we, rd, rd_data, busy, lq_count
  );

  // Write front end side.
  modport slave (
    input  issue_valid, issue_rd,
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready, alu_stall,
    output reg_we, rd, rd_data, busy, lq_count
  );
endinterface

// File: rtl/reg_writeback.sv
// Register-file write front end. ALU results always take the single write
// port; load responses wait in a small FIFO and drain whenever the ALU is
// idle. A starvation counter asks execute to hold off the ALU, and a
// pending-load scoreboard feeds decode hazard detection.
module reg_writeback #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rst,
  reg_writeback_if.slave  wb
);
  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;
  localparam int ST_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int NREG  = 1 << ADDR_W;

  localparam logic [CNT_W-1:0]  LQ_FULL  = CNT_W'(LQ_DEPTH);
  localparam logic [ST_W-1:0]   ST_MAX   = ST_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] REG_ZERO = {ADDR_W{1'b0}};

  // Queue storage and pointers
  logic [ADDR_W-1:0] lq_rd_q   [LQ_DEPTH];
  logic [ADDR_W-1:0] lq_rd_d   [LQ_DEPTH];
  logic [DATA_W-1:0] lq_data_q [LQ_DEPTH];
  logic [DATA_W-1:0] lq_data_d [LQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  // Starvation counter, scoreboard, write stage
  logic [ST_W-1:0]   starve_q,  starve_d;
  logic [NREG-1:0]   busy_q,    busy_d;
  logic              reg_we_q,  reg_we_d;
  logic [ADDR_W-1:0] rd_q,      rd_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Per-cycle decisions
  logic              lq_empty_s;
  logic              lq_full_s;
  logic              ready_s;
  logic              push_s;
  logic              pop_s;
  logic              sel_s;
  logic [ADDR_W-1:0] sel_rd_s;
  logic [DATA_W-1:0] sel_data_s;

  // Queue status, accept handshake and write-port arbitration (ALU first).
  always_comb begin
    lq_empty_s = (count_q == CNT_W'(0));
    lq_full_s  = (count_q == LQ_FULL);
    // Full blocks acceptance even if the head pops this cycle.
    ready_s    = !rst && !lq_full_s;
    push_s     = wb.ld_valid && ready_s;
    // No bypass: only entries already queued at the start of the cycle pop.
    pop_s      = !wb.alu_valid && !lq_empty_s;
    if (wb.alu_valid) begin
      sel_s      = 1'b1;
      sel_rd_s   = wb.alu_rd;
      sel_data_s = wb.alu_data;
    end else if (!lq_empty_s) begin
      sel_s      = 1'b1;
      sel_rd_s   = lq_rd_q[rd_ptr_q];
      sel_data_s = lq_data_q[rd_ptr_q];
    end else begin
      sel_s      = 1'b0;
      sel_rd_s   = REG_ZERO;
      sel_data_s = {DATA_W{1'b0}};
    end
  end

  // Queue next state: write at tail on push, advance head on pop.
  always_comb begin
    lq_rd_d   = lq_rd_q;
    lq_data_d = lq_data_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_s) begin
      lq_rd_d[wr_ptr_q]   = wb.ld_rd;
      lq_data_d[wr_ptr_q] = wb.ld_data;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Starvation: count consecutive cycles a queued head loses to the ALU.
  always_comb begin
    starve_d = starve_q;
    if (!lq_empty_s && wb.alu_valid) begin
      if (starve_q == ST_MAX) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + ST_W'(1);
      end
    end else begin
      starve_d = ST_W'(0);
    end
  end

  // Scoreboard: clear on pop of a queued load, set on issue (set wins).
  always_comb begin
    busy_d = busy_q;
    if (pop_s) begin
      busy_d[sel_rd_s] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (wb.issue_valid && (wb.issue_rd != REG_ZERO)) begin
      busy_d[wb.issue_rd] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Write stage: x0 writes suppressed, index/data hold when idle.
  always_comb begin
    reg_we_d = sel_s && (sel_rd_s != REG_ZERO);
    if (sel_s) begin
      rd_d      = sel_rd_s;
      rd_data_d = sel_data_s;
    end else begin
      rd_d      = rd_q;
      rd_data_d = rd_data_q;
    end
  end

  // State registers; reset discards queued loads and any in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_rd_q[i]   <= REG_ZERO;
        lq_data_q[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_q  <= PTR_W'(0);
      rd_ptr_q  <= PTR_W'(0);
      count_q   <= CNT_W'(0);
      starve_q  <= ST_W'(0);
      busy_q    <= {NREG{1'b0}};
      reg_we_q  <= 1'b0;
      rd_q      <= REG_ZERO;
      rd_data_q <= {DATA_W{1'b0}};
    end else begin
      lq_rd_q   <= lq_rd_d;
      lq_data_q <= lq_data_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      busy_q    <= busy_d;
      reg_we_q  <= reg_we_d;
      rd_q      <= rd_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign wb.ld_ready  = ready_s;
  assign wb.alu_stall = (starve_q == ST_MAX);
  assign wb.reg_we    = reg_we_q;
  assign wb.rd        = rd_q;
  assign wb.rd_data   = rd_data_q;
  assign wb.busy      = busy_q;
  assign wb.lq_count  = count_q;
endmodule
